// File: rtl/vga_pkg.sv
// Shared constants and colour helper for the VGA sprite compositor.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam logic [7:0] TRANSP_DEFAULT = 8'hE3;

    // Expand RRRGGGBB to the 12-bit pin order {B,G,R}; each channel is
    // left-justified with zero-filled LSBs.
    function automatic logic [11:0] rgb332_to_rgb444(input logic [7:0] d);
        return {d[1:0], 2'b00, d[4:2], 1'b0, d[7:5], 1'b0};
    endfunction

endpackage

// File: rtl/vga_sprite_unit.sv
// One sprite channel: frame-latched position/enable, beam hit test and ROM address.
module vga_sprite_unit
    import vga_pkg::*;
#(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int SPR_AW = 10
) (
    input  logic               clk25m,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic               valid_in,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic               spr_en,
    output logic [SPR_AW-1:0]  spr_addr,
    output logic               inside_s2
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam logic [COORD_W:0] W_LIM = (COORD_W + 1)'(SPR_W);
    localparam logic [COORD_W:0] H_LIM = (COORD_W + 1)'(SPR_H);

    logic [COORD_W-1:0] sx_reg, sy_reg;
    logic               en_reg;
    logic [COORD_W:0]   dx, dy;
    logic               inside_next, inside_s1_reg, inside_s2_reg;
    logic [SPR_AW-1:0]  addr_next, addr_reg;

    // The MSB of the 11-bit difference is the borrow: beam left of / above the sprite.
    assign dx = {1'b0, px} - {1'b0, sx_reg};
    assign dy = {1'b0, py} - {1'b0, sy_reg};

    assign inside_next = valid_in & en_reg & ~dx[COORD_W] & ~dy[COORD_W]
                       & (dx < W_LIM) & (dy < H_LIM);
    assign addr_next   = inside_next ? SPR_AW'({dy[YW-1:0], dx[XW-1:0]}) : '0;

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            sx_reg        <= '0;
            sy_reg        <= '0;
            en_reg        <= 1'b0;
            addr_reg      <= '0;
            inside_s1_reg <= 1'b0;
            inside_s2_reg <= 1'b0;
        end else begin
            if (frame_tick) begin
                sx_reg <= spr_x;
                sy_reg <= spr_y;
                en_reg <= spr_en;
            end
            addr_reg      <= addr_next;
            inside_s1_reg <= inside_next;
            inside_s2_reg <= inside_s1_reg;
        end
    end

    assign spr_addr  = addr_reg;
    assign inside_s2 = inside_s2_reg;

endmodule

// File: rtl/vga_sprite_layer.sv
// Sprite compositor: background addressing, per-sprite channels, priority mux,
// sync delay line and per-frame collision reporting.
module vga_sprite_layer
    import vga_pkg::*;
#(
    parameter int         NUM_SPRITES = 4,
    parameter int         SPR_W       = 32,
    parameter int         SPR_H       = 32,
    parameter int         SPR_AW      = 10,
    parameter int         REAL_WIDTH  = 640,
    parameter int         BG_AW       = 19,
    parameter logic [7:0] TRANSP      = TRANSP_DEFAULT
) (
    input  logic                            clk25m,
    input  logic                            rst_n,
    input  logic [COORD_W-1:0]              px,
    input  logic [COORD_W-1:0]              py,
    input  logic                            valid_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            frame_tick,
    input  logic [NUM_SPRITES*COORD_W-1:0]  spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]  spr_y,
    input  logic [NUM_SPRITES-1:0]          spr_en,
    output logic [BG_AW-1:0]                bg_addr,
    input  logic [7:0]                      bg_data,
    output logic [NUM_SPRITES*SPR_AW-1:0]   spr_addr,
    input  logic [NUM_SPRITES*8-1:0]        spr_data,
    output logic [11:0]                     rgb,
    output logic                            hsync,
    output logic                            vsync,
    output logic [NUM_SPRITES-1:0]          collide
);

    logic [BG_AW-1:0]       bg_addr_reg, bg_addr_next;
    logic                   valid_s1_reg, valid_s2_reg;
    logic [1:0]             sync_s1_reg, sync_s2_reg, sync_s3_reg;
    logic [NUM_SPRITES-1:0] inside_s2, opaque, hit;
    logic [NUM_SPRITES-1:0] acc_reg, collide_reg;
    logic [7:0]             pix_sel;
    logic [11:0]            rgb_reg, rgb_next;

    assign bg_addr_next = valid_in ? BG_AW'(px) + BG_AW'(py) * BG_AW'(REAL_WIDTH) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
            vga_sprite_unit #(
                .SPR_W  (SPR_W),
                .SPR_H  (SPR_H),
                .SPR_AW (SPR_AW)
            ) u_spr (
                .clk25m     (clk25m),
                .rst_n      (rst_n),
                .frame_tick (frame_tick),
                .px         (px),
                .py         (py),
                .valid_in   (valid_in),
                .spr_x      (spr_x[gi*COORD_W +: COORD_W]),
                .spr_y      (spr_y[gi*COORD_W +: COORD_W]),
                .spr_en     (spr_en[gi]),
                .spr_addr   (spr_addr[gi*SPR_AW +: SPR_AW]),
                .inside_s2  (inside_s2[gi])
            );

            assign opaque[gi] = inside_s2[gi] & (spr_data[gi*8 +: 8] != TRANSP);
            // A sprite collides when any other sprite is opaque on the same pixel.
            assign hit[gi]    = opaque[gi] & |(opaque & ~(NUM_SPRITES'(1) << gi));
        end
    endgenerate

    // Scan from lowest priority upward so sprite 0 wins.
    always_comb begin
        pix_sel = bg_data;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) pix_sel = spr_data[i*8 +: 8];
        end
        rgb_next = valid_s2_reg ? rgb332_to_rgb444(pix_sel) : 12'h000;
    end

    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            bg_addr_reg  <= '0;
            valid_s1_reg <= 1'b0;
            valid_s2_reg <= 1'b0;
            sync_s1_reg  <= '0;
            sync_s2_reg  <= '0;
            sync_s3_reg  <= '0;
            rgb_reg      <= '0;
            acc_reg      <= '0;
            collide_reg  <= '0;
        end else begin
            bg_addr_reg  <= bg_addr_next;
            valid_s1_reg <= valid_in;
            valid_s2_reg <= valid_s1_reg;
            sync_s1_reg  <= {hsync_in, vsync_in};
            sync_s2_reg  <= sync_s1_reg;
            sync_s3_reg  <= sync_s2_reg;
            rgb_reg      <= rgb_next;
            if (frame_tick) begin
                collide_reg <= acc_reg | hit;
                acc_reg     <= '0;
            end else begin
                acc_reg     <= acc_reg | hit;
            end
        end
    end

    assign bg_addr = bg_addr_reg;
    assign rgb     = rgb_reg;
    assign hsync   = sync_s3_reg[1];
    assign vsync   = sync_s3_reg[0];
    assign collide = collide_reg;

endmodule
